// File: rtl/writeback_commit_l4_pkg.sv
// Shared types and helpers for the in-order writeback/commit unit.
// Reorder-table entries omit the sequence number because it is the entry index.
package writeback_commit_l4_pkg;

  localparam int MAX_SEQ_BITS = 8;

  typedef struct packed {
    logic [31:0]             pc;
    logic [MAX_SEQ_BITS-1:0] seq_num;
    logic [4:0]              waddr;
    logic [31:0]             wdata;
    logic                    wen;
  } t_commit_msg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
  } t_rob_entry;

  // Register x0 is hard-wired to zero, so writes to it never reach the file.
  function automatic logic rf_wen(input logic wen, input logic [4:0] waddr);
    return wen && (waddr != 5'd0);
  endfunction

  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/writeback_commit_l4_arb.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
// The search runs from the far end so the nearest requester is written last.
module RoundRobinArbiter
  import writeback_commit_l4_pkg::*;
#(
  parameter int p_num_reqs = 4,
  localparam int PW = ptr_bits(p_num_reqs)
) (
  input  logic [p_num_reqs-1:0] req,
  input  logic [PW-1:0]         ptr,
  output logic [p_num_reqs-1:0] gnt,
  output logic [PW-1:0]         gnt_idx
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = p_num_reqs - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % p_num_reqs;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/writeback_commit_l4.sv
// In-order writeback/commit: accepts out-of-order completions from several
// execute pipes into a reorder table and retires them in sequence order.
module writeback_commit_l4
  import writeback_commit_l4_pkg::*;
#(
  parameter int p_seq_num_bits = 5,
  parameter int p_num_pipes    = 4,
  localparam int PW = ptr_bits(p_num_pipes)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_pipes-1:0][31:0]          x_pc,
  input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0] x_seq_num,
  input  logic [p_num_pipes-1:0][4:0]           x_waddr,
  input  logic [p_num_pipes-1:0][31:0]          x_wdata,
  input  logic [p_num_pipes-1:0]                x_wen,
  input  logic [p_num_pipes-1:0]                x_val,
  output logic [p_num_pipes-1:0]                x_rdy,
  output logic                                  commit_val,
  input  logic                                  commit_rdy,
  output logic [31:0]                           commit_pc,
  output logic [p_seq_num_bits-1:0]             commit_seq_num,
  output logic [4:0]                            commit_waddr,
  output logic [31:0]                           commit_wdata,
  output logic                                  commit_wen,
  output logic [p_seq_num_bits:0]               trace_count,
  output logic [p_seq_num_bits-1:0]             trace_head,
  output logic [PW-1:0]                         trace_gnt
);

  localparam int N_ENT = 1 << p_seq_num_bits;

  logic [N_ENT-1:0]          valid_reg;
  logic [p_seq_num_bits-1:0] head_reg;
  logic [PW-1:0]             rr_ptr_reg;
  logic [p_seq_num_bits:0]   count_reg;
  t_rob_entry                table_mem [N_ENT];

  logic [p_num_pipes-1:0]    gnt;
  logic [PW-1:0]             gnt_idx;
  logic [p_seq_num_bits-1:0] sel_seq;
  logic                      fire;
  logic                      retire;
  t_rob_entry                sel_entry;
  t_rob_entry                head_entry;

  RoundRobinArbiter #(.p_num_reqs(p_num_pipes)) u_arb (
    .req     (x_val),
    .ptr     (rr_ptr_reg),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Only the granted pipe may fire, and only into a free slot; rdy stays low in reset.
  assign sel_seq = x_seq_num[gnt_idx];
  assign fire    = rst && (|gnt) && !valid_reg[sel_seq];

  for (genvar gi = 0; gi < p_num_pipes; gi++) begin : g_rdy
    assign x_rdy[gi] = fire && gnt[gi];
  end

  always_comb begin
    sel_entry       = '0;
    sel_entry.pc    = x_pc[gnt_idx];
    sel_entry.waddr = x_waddr[gnt_idx];
    sel_entry.wdata = x_wdata[gnt_idx];
    sel_entry.wen   = x_wen[gnt_idx];
  end

  assign head_entry     = table_mem[head_reg];
  assign commit_val     = valid_reg[head_reg];
  assign retire         = commit_val && commit_rdy;
  assign commit_pc      = head_entry.pc;
  assign commit_seq_num = head_reg;
  assign commit_waddr   = head_entry.waddr;
  assign commit_wdata   = head_entry.wdata;
  assign commit_wen     = retire && rf_wen(head_entry.wen, head_entry.waddr);

  assign trace_count = count_reg;
  assign trace_head  = head_reg;
  assign trace_gnt   = gnt_idx;

  always_ff @(posedge clk) begin
    if (fire) table_mem[sel_seq] <= sel_entry;
  end

  // A fire and a retire never target the same entry: one needs valid=0, the other valid=1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg  <= '0;
      head_reg   <= '0;
      rr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (retire) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + 1'b1;
      end
      if (fire) begin
        valid_reg[sel_seq] <= 1'b1;
        rr_ptr_reg         <= (gnt_idx == PW'(p_num_pipes - 1)) ? '0 : gnt_idx + 1'b1;
      end
      case ({fire, retire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_commit_l4.sv
// Bench for writeback_commit_l4: directed scenarios then random traffic,
// all checked against a reorder-buffer model built from arrays and a queue.
module tb_writeback_commit_l4;
  import writeback_commit_l4_pkg::*;

  localparam int SB = 3;
  localparam int NP = 4;
  localparam int NE = 1 << SB;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NP-1:0][31:0]          x_pc;
  logic [NP-1:0][SB-1:0]        x_seq_num;
  logic [NP-1:0][4:0]           x_waddr;
  logic [NP-1:0][31:0]          x_wdata;
  logic [NP-1:0]                x_wen;
  logic [NP-1:0]                x_val;
  logic [NP-1:0]                x_rdy;
  logic                         commit_val;
  logic                         commit_rdy;
  logic [31:0]                  commit_pc;
  logic [SB-1:0]                commit_seq_num;
  logic [4:0]                   commit_waddr;
  logic [31:0]                  commit_wdata;
  logic                         commit_wen;
  logic [SB:0]                  trace_count;
  logic [SB-1:0]                trace_head;
  logic [1:0]                   trace_gnt;

  writeback_commit_l4 #(.p_seq_num_bits(SB), .p_num_pipes(NP)) dut (
    .clk(clk), .rst(rst),
    .x_pc(x_pc), .x_seq_num(x_seq_num), .x_waddr(x_waddr), .x_wdata(x_wdata),
    .x_wen(x_wen), .x_val(x_val), .x_rdy(x_rdy),
    .commit_val(commit_val), .commit_rdy(commit_rdy), .commit_pc(commit_pc),
    .commit_seq_num(commit_seq_num), .commit_waddr(commit_waddr),
    .commit_wdata(commit_wdata), .commit_wen(commit_wen),
    .trace_count(trace_count), .trace_head(trace_head), .trace_gnt(trace_gnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: occupancy + contents per sequence number, oldest pointer, rotation pointer.
  bit          m_valid [NE];
  t_commit_msg m_entry [NE];
  int          m_head;
  int          m_rr;
  int          cyc;
  int          fired;
  int          fire_cyc;
  bit          did_commit;
  bit          allow_block;
  int          log_seq[$];
  int          log_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NE; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
    m_head = 0;
    m_rr   = 0;
    log_seq.delete();
    log_cyc.delete();
  endtask

  // One clock: compare all outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    int g;
    int s;
    bit blocked;
    bit cv;
    logic [NP-1:0] exp_rdy;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (m_rr + k) % NP;
      if (g < 0 && x_val[p]) g = p;
    end
    exp_rdy = '0;
    blocked = 1'b0;
    s = 0;
    if (g >= 0) begin
      s = int'(x_seq_num[g]);
      if (!m_valid[s]) exp_rdy[g] = 1'b1;
      else blocked = 1'b1;
    end
    check("rdy", x_rdy, exp_rdy);
    if (blocked) begin
      checks++;
      assert (allow_block) else begin
        errors++;
        $error("FAIL blocked_grant observed=seq%0d_occupied expected=free_slot", s);
      end
    end
    if (g >= 0) check("gnt_idx", trace_gnt, g);
    cv = m_valid[m_head];
    check("commit_val", commit_val, cv);
    check("count", trace_count, model_count());
    check("head", trace_head, m_head);
    if (cv) begin
      check("commit_pc", commit_pc, m_entry[m_head].pc);
      check("commit_seq", commit_seq_num, m_head);
      check("commit_waddr", commit_waddr, m_entry[m_head].waddr);
      check("commit_wdata", commit_wdata, m_entry[m_head].wdata);
    end
    check("commit_wen", commit_wen,
          cv && commit_rdy && m_entry[m_head].wen && (m_entry[m_head].waddr != 5'd0));
    @(posedge clk);
    cyc++;
    did_commit = 1'b0;
    fired = -1;
    if (cv && commit_rdy) begin
      log_seq.push_back(m_head);
      log_cyc.push_back(cyc);
      m_valid[m_head] = 1'b0;
      m_head = (m_head + 1) % NE;
      did_commit = 1'b1;
    end
    if (exp_rdy != '0) begin
      m_valid[s]         = 1'b1;
      m_entry[s].pc      = x_pc[g];
      m_entry[s].seq_num = MAX_SEQ_BITS'(s);
      m_entry[s].waddr   = x_waddr[g];
      m_entry[s].wdata   = x_wdata[g];
      m_entry[s].wen     = x_wen[g];
      m_rr     = (g + 1) % NP;
      fired    = g;
      fire_cyc = cyc;
    end
    #1;
  endtask

  task automatic send(input int p, input int seq, input logic [31:0] pc,
                      input logic [4:0] waddr, input logic [31:0] wdata, input logic wen);
    x_pc[p]      = pc;
    x_seq_num[p] = SB'(seq);
    x_waddr[p]   = waddr;
    x_wdata[p]   = wdata;
    x_wen[p]     = wen;
    x_val[p]     = 1'b1;
  endtask

  // Reset with every pipe requesting, to show rdy is held low while reset is active.
  task automatic do_reset();
    x_val = '1;
    rst   = 1'b0;
    #1;
    check("rst_commit_val", commit_val, 1'b0);
    check("rst_commit_wen", commit_wen, 1'b0);
    check("rst_rdy", x_rdy, '0);
    check("rst_head", trace_head, 0);
    check("rst_count", trace_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    x_val = '0;
    rst   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  inflight;
    int  tail;
    int  pool[$];
    bit  pend[NP];
    int  fc;

    rst = 1'b1; x_pc = '0; x_seq_num = '0; x_waddr = '0; x_wdata = '0;
    x_wen = '0; x_val = '0; commit_rdy = 1'b0;
    cyc = 0; allow_block = 1'b0; fired = -1; fire_cyc = 0;
    model_reset();
    @(posedge clk); #1;

    // Single write.
    do_reset();
    commit_rdy = 1'b1;
    send(0, 0, 32'h200, 5'd5, 32'hDEADBEEF, 1'b1);
    step();
    check("t1_fire", fired, 0);
    x_val = '0;
    check("t1_val", commit_val, 1'b1);
    check("t1_pc", commit_pc, 32'h200);
    check("t1_seq", commit_seq_num, 0);
    check("t1_waddr", commit_waddr, 5);
    check("t1_wdata", commit_wdata, 32'hDEADBEEF);
    check("t1_wen", commit_wen, 1'b1);
    step();
    check("t1_ncommit", log_seq.size(), 1);

    // Out-of-order arrival.
    do_reset();
    commit_rdy = 1'b1;
    for (int k = 2; k >= 0; k--) begin
      send(k, k, 32'h1000 + k * 4, 5'(k + 1), 32'hA0 + k, 1'b1);
      step();
      x_val = '0;
    end
    fc = fire_cyc;
    repeat (4) step();
    check("t2_ncommit", log_seq.size(), 3);
    for (int i = 0; i < 3 && i < log_seq.size(); i++) begin
      check("t2_order", log_seq[i], i);
      check("t2_cycle", log_cyc[i], fc + 1 + i);
    end

    // Arbitration among four simultaneous requesters.
    do_reset();
    commit_rdy = 1'b1;
    for (int p = 0; p < NP; p++) send(p, p, 32'h3000 + p * 4, 5'(p + 8), 32'hB0 + p, 1'b1);
    for (int k = 0; k < NP; k++) begin
      step();
      check("t3_grant_order", fired, k);
      if (fired >= 0) x_val[fired] = 1'b0;
    end
    repeat (3) step();
    check("t3_ncommit", log_seq.size(), 4);
    for (int i = 0; i < 4 && i < log_seq.size(); i++) begin
      check("t3_order", log_seq[i], i);
      if (i > 0) check("t3_spacing", log_cyc[i], log_cyc[i-1] + 1);
    end

    // Fill the table, stall a ninth message, then drain through the wrap.
    do_reset();
    commit_rdy = 1'b0;
    for (int k = 0; k < NE; k++) begin
      send(k % NP, k, 32'h4000 + k * 4, 5'(k + 1), 32'hC0 + k, 1'b1);
      step();
      check("t4_fill", fired, k % NP);
      x_val = '0;
    end
    check("t4_full", trace_count, NE);
    allow_block = 1'b1;
    send(0, 0, 32'h900, 5'd9, 32'h9999, 1'b1);
    #1;
    check("t4_stall_rdy", x_rdy, '0);
    step();
    check("t4_stalled", fired, -1);
    commit_rdy = 1'b1;
    step();
    check("t4_free_cycle", fired, -1);
    step();
    check("t4_refill", fired, 0);
    allow_block = 1'b0;
    x_val = '0;
    repeat (10) step();
    check("t4_ncommit", log_seq.size(), NE + 1);
    for (int i = 0; i < log_seq.size(); i++) check("t4_order", log_seq[i], i % NE);
    check("t4_head_wrap", trace_head, 1);

    // Write to x0 still commits, without a register-file write.
    do_reset();
    commit_rdy = 1'b1;
    send(1, 0, 32'h500, 5'd0, 32'h1234, 1'b1);
    step();
    x_val = '0;
    check("t5_val", commit_val, 1'b1);
    check("t5_wen", commit_wen, 1'b0);
    step();
    check("t5_ncommit", log_seq.size(), 1);

    // Reset drops buffered entries; a fresh seq 0 then commits normally.
    do_reset();
    commit_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(k, k, 32'h600 + k * 4, 5'd3, 32'hD0 + k, 1'b1);
      step();
      x_val = '0;
    end
    check("t6_buffered", trace_count, 3);
    do_reset();
    commit_rdy = 1'b1;
    send(2, 0, 32'h700, 5'd7, 32'h7777, 1'b1);
    step();
    x_val = '0;
    step();
    check("t6_ncommit", log_seq.size(), 1);
    if (log_seq.size() > 0) check("t6_seq", log_seq[0], 0);

    // Random traffic: in-order allocation, at most NE in flight, out-of-order completion.
    do_reset();
    inflight = 0;
    tail = 0;
    for (int p = 0; p < NP; p++) pend[p] = 1'b0;
    repeat (600) begin
      if (inflight < NE && $urandom_range(0, 2) != 0) begin
        pool.push_back(tail);
        tail = (tail + 1) % NE;
        inflight++;
      end
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && pool.size() > 0 && $urandom_range(0, 1) == 1) begin
          int idx;
          idx = $urandom_range(0, pool.size() - 1);
          x_seq_num[p] = SB'(pool[idx]);
          pool.delete(idx);
          pend[p]    = 1'b1;
          x_pc[p]    = $urandom;
          x_waddr[p] = 5'($urandom_range(0, 31));
          x_wdata[p] = $urandom;
          x_wen[p]   = 1'($urandom_range(0, 1));
        end
        x_val[p] = pend[p];
      end
      commit_rdy = ($urandom_range(0, 3) != 0);
      step();
      if (fired >= 0) begin
        pend[fired]  = 1'b0;
        x_val[fired] = 1'b0;
      end
      if (did_commit) inflight--;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
